// File: rtl/countdown_pkg.sv
// Shared types and default sizes for the countdown sequencer and its button conditioners.
package countdown_pkg;

  localparam int unsigned CD_N            = 6;
  localparam int unsigned CD_SYNC_STAGES  = 2;
  localparam int unsigned CD_DEBOUNCE_CYC = 4;
  localparam int unsigned CD_TICK_CYC     = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_MAN  = 2'd1,
    RUN_AUTO = 2'd2,
    DONE     = 2'd3
  } cd_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/countdown_ctrl_debounce.sv
// Button conditioner: synchroniser chain, stability debounce and a rising-edge press pulse.
module btn_debounce
  import countdown_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = CD_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYC = CD_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced_c;

  assign synced_c = sync_q[SYNC_STAGES-1];

  // Level flips on the DEBOUNCE_CYC-th consecutive cycle the synced input disagrees with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(btn_raw);
      press  <= 1'b0;
      if (synced_c == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        cnt_q <= '0;
        level <= synced_c;
        press <= synced_c;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: conditions three buttons and steps an external down-counter
// manually or on a fixed tick, stopping when the counter reads zero.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned N            = CD_N,
  parameter int unsigned SYNC_STAGES  = CD_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYC = CD_DEBOUNCE_CYC,
  parameter int unsigned TICK_CYC     = CD_TICK_CYC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_load,
  input  logic         btn_decr,
  input  logic         btn_auto,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] count_i,
  output logic         load_o,
  output logic         decr_o,
  output logic         auto_o,
  output logic         done_o
);

  localparam int unsigned TW = cnt_width(TICK_CYC);

  cd_state_t     state;
  logic [TW-1:0] tick_q;
  logic          p_load, p_decr, p_auto;
  logic [2:0]    unused_levels;
  logic          unused_load_val;
  logic          load_cmd_c, auto_cmd_c, decr_cmd_c;
  logic          settle_c, zero_c, decr_ok_c, tick_last_c;

  // load_val feeds the counter directly; this block only sequences it.
  assign unused_load_val = ^load_val;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_load (
    .clk(clk), .rst(rst), .btn_raw(btn_load), .level(unused_levels[0]), .press(p_load)
  );
  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_decr (
    .clk(clk), .rst(rst), .btn_raw(btn_decr), .level(unused_levels[1]), .press(p_decr)
  );
  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_auto (
    .clk(clk), .rst(rst), .btn_raw(btn_auto), .level(unused_levels[2]), .press(p_auto)
  );

  // Same-cycle presses resolve load > auto > decr; losers are dropped.
  assign load_cmd_c = p_load;
  assign auto_cmd_c = p_auto & ~p_load;
  assign decr_cmd_c = p_decr & ~p_load & ~p_auto;

  // While a command is on the wire count_i still shows the pre-command value.
  assign settle_c    = load_o | decr_o;
  assign zero_c      = (count_i == '0) && !settle_c;
  assign decr_ok_c   = (count_i != '0) && !settle_c;
  assign tick_last_c = (tick_q == TW'(TICK_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tick_q <= '0;
      load_o <= 1'b0;
      decr_o <= 1'b0;
      auto_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      load_o <= 1'b0;
      decr_o <= 1'b0;
      case (state)
        IDLE: begin
          if (load_cmd_c) begin
            load_o <= 1'b1;
            state  <= RUN_MAN;
          end
        end

        RUN_MAN: begin
          if (load_cmd_c) begin
            load_o <= 1'b1;
          end else if (auto_cmd_c) begin
            state  <= RUN_AUTO;
            auto_o <= 1'b1;
            tick_q <= '0;
          end else if (zero_c) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else if (decr_cmd_c && decr_ok_c) begin
            decr_o <= 1'b1;
          end
        end

        RUN_AUTO: begin
          if (load_cmd_c) begin
            load_o <= 1'b1;
            tick_q <= '0;
          end else if (auto_cmd_c) begin
            state  <= RUN_MAN;
            auto_o <= 1'b0;
            tick_q <= '0;
          end else if (zero_c) begin
            state  <= DONE;
            auto_o <= 1'b0;
            done_o <= 1'b1;
            tick_q <= '0;
          end else if (tick_last_c) begin
            tick_q <= '0;
            decr_o <= decr_ok_c;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end

        DONE: begin
          if (load_cmd_c) begin
            load_o <= 1'b1;
            done_o <= 1'b0;
            state  <= RUN_MAN;
          end
        end

        default: begin
          state  <= IDLE;
          tick_q <= '0;
          auto_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a registered down-counter model closing the loop.
module tb_countdown_ctrl;
  import countdown_pkg::*;

  localparam int unsigned N = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_load = 1'b0;
  logic         btn_decr = 1'b0;
  logic         btn_auto = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] count = '0;
  logic         load_o, decr_o, auto_o, done_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_load = 0;
  int n_decr = 0;
  int wraps = 0;
  int decr_cyc = 0;
  int decr_cyc_prev = 0;
  int auto_rise_cyc = 0;
  logic auto_q = 1'b0;

  always #5 clk = ~clk;

  countdown_ctrl #(.N(N), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .TICK_CYC(5)) dut (
    .clk(clk), .rst(rst), .btn_load(btn_load), .btn_decr(btn_decr), .btn_auto(btn_auto),
    .load_val(load_val), .count_i(count), .load_o(load_o), .decr_o(decr_o),
    .auto_o(auto_o), .done_o(done_o)
  );

  // Counter model: samples the commands on the same edge it updates.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_o) count <= load_val;
    else if (decr_o) count <= count - N'(1);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (load_o) n_load <= n_load + 1;
      if (decr_o) begin
        n_decr <= n_decr + 1;
        decr_cyc_prev <= decr_cyc;
        decr_cyc <= cyc;
        if (count == '0) wraps <= wraps + 1;
      end
      if (auto_o && !auto_q) auto_rise_cyc <= cyc;
      auto_q <= auto_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic l, input logic d, input logic a);
    @(negedge clk);
    btn_load = l; btn_decr = d; btn_auto = a;
    repeat (10) @(negedge clk);
    btn_load = 1'b0; btn_decr = 1'b0; btn_auto = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int l0, d0, lat, seen;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_load_o", 32'(load_o), 32'd0);
    check("rst_decr_o", 32'(decr_o), 32'd0);
    check("rst_auto_o", 32'(auto_o), 32'd0);
    check("rst_done_o", 32'(done_o), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));

    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("idle_no_load", 32'(n_load), 32'd0);
    check("idle_no_decr", 32'(n_decr), 32'd0);
    check("idle_state", 32'(dut.state), 32'(IDLE));
    check("idle_auto_o", 32'(auto_o), 32'd0);

    // Bouncing load button, value 3
    load_val = N'(3);
    @(negedge clk); btn_load = 1'b1;
    @(negedge clk); btn_load = 1'b0;
    @(negedge clk); btn_load = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (load_o && lat == 0) lat = i;
    end
    check("bounce_latency_in_window", 32'(lat >= 6 && lat <= 7), 32'd1);
    repeat (4) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_one_load", 32'(n_load), 32'd1);
    check("bounce_count", 32'(count), 32'd3);
    check("bounce_state", 32'(dut.state), 32'(RUN_MAN));

    // Manual countdown 3 -> 0
    d0 = n_decr;
    press(1'b0, 1'b1, 1'b0);
    check("man_decr1_count", 32'(count), 32'd2);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("man_three_decr", 32'(n_decr - d0), 32'd3);
    check("man_count_zero", 32'(count), 32'd0);
    check("man_done_o", 32'(done_o), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    check("man_fourth_no_decr", 32'(n_decr - d0), 32'd3);
    check("man_still_done", 32'(done_o), 32'd1);

    // Auto countdown 2 -> 0
    load_val = N'(2);
    press(1'b1, 1'b0, 1'b0);
    check("auto_load_count", 32'(count), 32'd2);
    check("auto_load_done_clr", 32'(done_o), 32'd0);
    d0 = n_decr;
    press(1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("auto_two_decr", 32'(n_decr - d0), 32'd2);
    check("auto_first_tick", 32'(decr_cyc_prev - auto_rise_cyc), 32'd5);
    check("auto_period", 32'(decr_cyc - decr_cyc_prev), 32'd5);
    check("auto_count_zero", 32'(count), 32'd0);
    check("auto_done_o", 32'(done_o), 32'd1);
    check("auto_auto_o_low", 32'(auto_o), 32'd0);

    // Auto toggled off mid-run
    load_val = N'(20);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("toggle_auto_on", 32'(auto_o), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("toggle_auto_off", 32'(auto_o), 32'd0);
    check("toggle_state_man", 32'(dut.state), 32'(RUN_MAN));
    d0 = n_decr;
    repeat (30) @(negedge clk);
    check("toggle_no_more_decr", 32'(n_decr - d0), 32'd0);
    check("toggle_not_done", 32'(done_o), 32'd0);

    // Simultaneous load+decr with load_val 0
    load_val = '0;
    l0 = n_load; d0 = n_decr;
    @(negedge clk); btn_load = 1'b1; btn_decr = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (load_o) seen = 1;
    end
    check("simul_load_seen", 32'(seen), 32'd1);
    check("simul_done_early", 32'(done_o), 32'd0);
    @(posedge clk); #1;
    check("simul_done_settle", 32'(done_o), 32'd0);
    @(posedge clk); #1;
    check("simul_done_after", 32'(done_o), 32'd1);
    repeat (3) @(negedge clk);
    btn_load = 1'b0; btn_decr = 1'b0;
    repeat (10) @(negedge clk);
    check("simul_one_load", 32'(n_load - l0), 32'd1);
    check("simul_no_decr", 32'(n_decr - d0), 32'd0);
    check("simul_state_done", 32'(dut.state), 32'(DONE));

    // Reset mid auto-run
    load_val = N'(10);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (decr_o) seen = 1;
    end
    check("rstrun_decr_seen", 32'(seen), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rstrun_load_o", 32'(load_o), 32'd0);
    check("rstrun_decr_o", 32'(decr_o), 32'd0);
    check("rstrun_auto_o", 32'(auto_o), 32'd0);
    check("rstrun_done_o", 32'(done_o), 32'd0);
    check("rstrun_state", 32'(dut.state), 32'(IDLE));
    check("rstrun_tick", 32'(dut.tick_q), 32'd0);
    @(negedge clk); rst = 1'b0;
    l0 = n_load; d0 = n_decr;
    repeat (20) @(negedge clk);
    check("rstrun_quiet_decr", 32'(n_decr - d0), 32'd0);
    check("rstrun_quiet_load", 32'(n_load - l0), 32'd0);
    check("rstrun_idle", 32'(dut.state), 32'(IDLE));
    load_val = N'(5);
    press(1'b1, 1'b0, 1'b0);
    check("rstrun_reload", 32'(n_load - l0), 32'd1);
    check("rstrun_reload_count", 32'(count), 32'd5);
    check("rstrun_reload_state", 32'(dut.state), 32'(RUN_MAN));
    check("never_wrapped", 32'(wraps), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
